ddp_out_sync_fifo: RTL and testbench



---
 rtl/ddp_out_sync_fifo.sv | 110 +++++++++++
 tb/tb_ddp_out_sync_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddp_out_sync_fifo.sv
// Output collector for the JOIN ring: synchronises the self-timed Send/Ack request
// into the CP domain and buffers packets in a show-ahead FIFO for a valid/ready consumer.
module ddp_out_sync_fifo #(
  parameter int PACKET_WIDTH = 38,
  parameter int DEPTH        = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                           CP,
  input  logic                           MR_N,
  input  logic                           Send_in,
  input  logic [PACKET_WIDTH-1:0]        PACKET_IN,
  output logic                           Ack_out,
  output logic [PACKET_WIDTH-1:0]        PACKET_OUT,
  output logic                           VALID_OUT,
  input  logic                           READY_IN,
  output logic [$clog2(DEPTH+1)-1:0]     COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [PACKET_WIDTH-1:0]  mem_q [DEPTH];

  logic req_s;
  logic push;
  logic pop;
  logic valid;

  assign req_s = sync_q[SYNC_STAGES-1];
  assign valid = (count_q != '0);
  assign pop   = valid && READY_IN;

  // Full check uses the pre-pop count, so a pop on a full FIFO defers the push by one edge.
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    sync_d   = {sync_q[SYNC_STAGES-2:0], Send_in};
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (req_s && (count_q < DEPTH_C)) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage is deliberately left unreset; the head is only meaningful while valid.
  always_ff @(posedge CP) begin
    if (push) begin
      mem_q[wr_ptr_q] <= PACKET_IN;
    end
  end

  assign Ack_out    = (state_q == ACK);
  assign VALID_OUT  = valid;
  assign COUNT      = count_q;
  assign PACKET_OUT = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ddp_out_sync_fifo.sv
// Directed self-checking bench for ddp_out_sync_fifo: a per-cycle vector table for
// the basic handshake plus hand-written sequences for full stall, wrap, reset and idle pops.
module tb_ddp_out_sync_fifo;

  localparam int PW = 38;

  logic          CP;
  logic          MR_N;
  logic          Send_in;
  logic [PW-1:0] PACKET_IN;
  logic          Ack_out;
  logic [PW-1:0] PACKET_OUT;
  logic          VALID_OUT;
  logic          READY_IN;
  logic [2:0]    COUNT;

  int checks   = 0;
  int failures = 0;

  logic          monitorOn = 1'b0;
  logic [PW-1:0] seenQ[$];

  typedef struct {
    logic          send;
    logic          ready;
    logic [PW-1:0] pkt;
    logic          expAck;
    logic          expValid;
    logic [2:0]    expCount;
    logic          chkPkt;
    logic [PW-1:0] expPkt;
  } vec_t;

  vec_t vecs[7];

  ddp_out_sync_fifo #(
    .PACKET_WIDTH(38),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .CP        (CP),
    .MR_N      (MR_N),
    .Send_in   (Send_in),
    .PACKET_IN (PACKET_IN),
    .Ack_out   (Ack_out),
    .PACKET_OUT(PACKET_OUT),
    .VALID_OUT (VALID_OUT),
    .READY_IN  (READY_IN),
    .COUNT     (COUNT)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  // Compare one observed value against its expectation and log a failure line.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later; optionally watch the stream.
  task automatic step();
    @(posedge CP);
    #1;
    if (monitorOn) begin
      checks++;
      if (COUNT > 3'd1) begin
        failures++;
        $display("[TB] FAIL streamCount: got %0d expected <=1", COUNT);
      end
      if (VALID_OUT && READY_IN) seenQ.push_back(PACKET_OUT);
    end
  endtask

  // Wait a bounded number of edges for Ack_out to reach the given level.
  task automatic waitAck(input logic level, input int budget, input string name);
    int n = 0;
    while (Ack_out !== level && n < budget) begin
      step();
      n++;
    end
    checkOutput(name, {63'd0, Ack_out}, {63'd0, level});
  endtask

  // Behave as the upstream sender for one full four-phase handshake.
  task automatic applyStimulus(input logic [PW-1:0] pkt);
    PACKET_IN = pkt;
    Send_in   = 1'b1;
    waitAck(1'b1, 20, "ackRise");
    Send_in   = 1'b0;
    waitAck(1'b0, 20, "ackFall");
  endtask

  // Check the head against an expected packet, then pop it with a one-cycle READY_IN.
  task automatic drainExpect(input logic [PW-1:0] exp);
    checkOutput("drainValid", {63'd0, VALID_OUT}, 64'd1);
    checkOutput("drainHead", {26'd0, PACKET_OUT}, {26'd0, exp});
    READY_IN = 1'b1;
    step();
    READY_IN = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 38'h12_3456_789A, 1'b0, 1'b0, 3'd0, 1'b0, '0};
    vecs[1] = '{1'b1, 1'b0, 38'h12_3456_789A, 1'b0, 1'b0, 3'd0, 1'b0, '0};
    vecs[2] = '{1'b1, 1'b0, 38'h12_3456_789A, 1'b1, 1'b1, 3'd1, 1'b1, 38'h12_3456_789A};
    vecs[3] = '{1'b0, 1'b0, 38'h12_3456_789A, 1'b1, 1'b1, 3'd1, 1'b1, 38'h12_3456_789A};
    vecs[4] = '{1'b0, 1'b0, 38'h12_3456_789A, 1'b1, 1'b1, 3'd1, 1'b0, '0};
    vecs[5] = '{1'b0, 1'b0, 38'h12_3456_789A, 1'b0, 1'b1, 3'd1, 1'b1, 38'h12_3456_789A};
    vecs[6] = '{1'b0, 1'b1, 38'h12_3456_789A, 1'b0, 1'b0, 3'd0, 1'b0, '0};

    MR_N      = 1'b0;
    Send_in   = 1'b0;
    READY_IN  = 1'b0;
    PACKET_IN = '0;
    #1;
    checkOutput("rstAck", {63'd0, Ack_out}, 64'd0);
    checkOutput("rstValid", {63'd0, VALID_OUT}, 64'd0);
    checkOutput("rstCount", {61'd0, COUNT}, 64'd0);
    step();
    step();
    MR_N = 1'b1;
    step();

    $display("[TB] single packet handshake table");
    for (int i = 0; i < 7; i++) begin
      Send_in   = vecs[i].send;
      READY_IN  = vecs[i].ready;
      PACKET_IN = vecs[i].pkt;
      step();
      checkOutput($sformatf("vecAck%0d", i), {63'd0, Ack_out}, {63'd0, vecs[i].expAck});
      checkOutput($sformatf("vecValid%0d", i), {63'd0, VALID_OUT}, {63'd0, vecs[i].expValid});
      checkOutput($sformatf("vecCount%0d", i), {61'd0, COUNT}, {61'd0, vecs[i].expCount});
      if (vecs[i].chkPkt) begin
        checkOutput($sformatf("vecPkt%0d", i), {26'd0, PACKET_OUT}, {26'd0, vecs[i].expPkt});
      end
    end
    READY_IN = 1'b0;

    $display("[TB] full stall and release");
    for (int p = 1; p <= 4; p++) applyStimulus(38'(p));
    checkOutput("fullCount", {61'd0, COUNT}, 64'd4);
    PACKET_IN = 38'd5;
    Send_in   = 1'b1;
    repeat (8) step();
    checkOutput("stallAck", {63'd0, Ack_out}, 64'd0);
    checkOutput("stallCount", {61'd0, COUNT}, 64'd4);
    checkOutput("stallHead", {26'd0, PACKET_OUT}, 64'd1);
    READY_IN = 1'b1;
    step();
    READY_IN = 1'b0;
    checkOutput("popEdgeAck", {63'd0, Ack_out}, 64'd0);
    checkOutput("popEdgeCount", {61'd0, COUNT}, 64'd3);
    checkOutput("popEdgeHead", {26'd0, PACKET_OUT}, 64'd2);
    step();
    checkOutput("lateAck", {63'd0, Ack_out}, 64'd1);
    checkOutput("lateCount", {61'd0, COUNT}, 64'd4);
    Send_in = 1'b0;
    waitAck(1'b0, 20, "lateAckFall");
    for (int p = 2; p <= 5; p++) drainExpect(38'(p));
    checkOutput("drainedCount", {61'd0, COUNT}, 64'd0);

    $display("[TB] streaming with READY_IN held high");
    READY_IN  = 1'b1;
    monitorOn = 1'b1;
    for (int p = 1; p <= 10; p++) applyStimulus(38'(p));
    repeat (2) step();
    monitorOn = 1'b0;
    READY_IN  = 1'b0;
    checkOutput("streamSeen", 64'(seenQ.size()), 64'd10);
    for (int k = 0; k < seenQ.size() && k < 10; k++) begin
      checkOutput($sformatf("streamPkt%0d", k), {26'd0, seenQ[k]}, 64'(k + 1));
    end
    checkOutput("streamEndCount", {61'd0, COUNT}, 64'd0);

    $display("[TB] simultaneous push and pop at COUNT=2");
    applyStimulus(38'd11);
    applyStimulus(38'd12);
    checkOutput("twoCount", {61'd0, COUNT}, 64'd2);
    PACKET_IN = 38'd13;
    Send_in   = 1'b1;
    step();
    step();
    checkOutput("prePushAck", {63'd0, Ack_out}, 64'd0);
    READY_IN = 1'b1;
    step();
    READY_IN = 1'b0;
    checkOutput("bothAck", {63'd0, Ack_out}, 64'd1);
    checkOutput("bothCount", {61'd0, COUNT}, 64'd2);
    checkOutput("bothHead", {26'd0, PACKET_OUT}, 64'd12);
    Send_in = 1'b0;
    waitAck(1'b0, 20, "bothAckFall");
    drainExpect(38'd12);
    drainExpect(38'd13);

    $display("[TB] asynchronous reset while acknowledging");
    applyStimulus(38'd21);
    applyStimulus(38'd22);
    PACKET_IN = 38'd23;
    Send_in   = 1'b1;
    waitAck(1'b1, 20, "rstAckRise");
    checkOutput("preRstCount", {61'd0, COUNT}, 64'd3);
    #2;
    MR_N = 1'b0;
    #1;
    checkOutput("asyncAck", {63'd0, Ack_out}, 64'd0);
    checkOutput("asyncValid", {63'd0, VALID_OUT}, 64'd0);
    checkOutput("asyncCount", {61'd0, COUNT}, 64'd0);
    Send_in = 1'b0;
    step();
    step();
    MR_N = 1'b1;
    step();
    checkOutput("postRstAck", {63'd0, Ack_out}, 64'd0);
    checkOutput("postRstCount", {61'd0, COUNT}, 64'd0);
    applyStimulus(38'd24);
    checkOutput("postRstOne", {61'd0, COUNT}, 64'd1);
    drainExpect(38'd24);

    $display("[TB] READY_IN high while empty");
    READY_IN = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      checkOutput("emptyCount", {61'd0, COUNT}, 64'd0);
      checkOutput("emptyValid", {63'd0, VALID_OUT}, 64'd0);
    end
    READY_IN = 1'b0;
    applyStimulus(38'h3F_0000_0001);
    checkOutput("afterEmptyCount", {61'd0, COUNT}, 64'd1);
    drainExpect(38'h3F_0000_0001);
    checkOutput("finalCount", {61'd0, COUNT}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
